rom_arbiter: RTL and testbench

- Round-robin arbiter that shares the ROM's second read port between NUM_REQ bus requesters, e.g. data load/store unit, debug module and DMA.
- Registers each access into a one-cycle-latency response.
- Converts byte addresses to word addresses and flags misaligned or out-of-range accesses.
- Sits between the bus masters and rom port 2. Port 1 stays dedicated to instruction fetch.

---
 rtl/rv32.sv | 6 +
 rtl/saratoga.sv | 21 ++
 rtl/rr_picker.sv | 33 +++
 rtl/rom_arbiter.sv | 108 ++++++++++
 tb/tb_rom_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32.sv
// Base RV32 data types shared by the core and its memory-side blocks.
package rv32;

  typedef logic [31:0] word;

endpackage

// File: rtl/saratoga.sv
// SoC-wide constants and ROM arbiter types.
// Also holds the address classifier used by rom_arbiter.
package saratoga;

  localparam int DEFAULT_ROM_ADDR_WIDTH  = 10;
  localparam int ROM_ARB_NUM_REQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    ROM_ARB_OK,
    ROM_ARB_MISALIGN,
    ROM_ARB_RANGE
  } rom_arb_err_e;

  // Misalignment takes precedence over range so a bad low address reports the more specific fault.
  function automatic rom_arb_err_e rom_arb_classify(input rv32::word addr, input int addr_width);
    if (addr[1:0] != 2'b00) return ROM_ARB_MISALIGN;
    if ((addr >> (addr_width + 2)) != '0) return ROM_ARB_RANGE;
    return ROM_ARB_OK;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot priority picker: the first set req bit at or above ptr (mod N) wins.
// Purely combinational so it can serve any shared-resource arbiter.
module rr_picker #(
  parameter int N = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int w_pos;

  // Scan from farthest to nearest offset so the nearest requester is the last (winning) assignment.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(ptr) + k) % N;
      if (req[w_pos]) begin
        gnt        = '0;
        gnt[w_pos] = 1'b1;
        idx        = IDX_W'(w_pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing ROM read port 2 between NUM_REQ bus masters, one-cycle response.
// Optional macro ROM_ARB_STATS_EN adds per-requester saturating grant counters.
module rom_arbiter
  import saratoga::*;
#(
  parameter int NUM_REQ    = ROM_ARB_NUM_REQ_DEFAULT,
  parameter int ADDR_WIDTH = DEFAULT_ROM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic      [NUM_REQ-1:0]   req_valid,
  input  rv32::word [NUM_REQ-1:0]   req_addr,
  output logic      [NUM_REQ-1:0]   req_ready,
  output logic      [NUM_REQ-1:0]   rsp_valid,
  output logic                      rsp_err,
  output rv32::word                 rsp_data,
  output logic                      rom_rd_en,
  output logic      [ADDR_WIDTH-1:0] rom_addr,
  input  rv32::word                 rom_rd_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic      [NUM_REQ-1:0][31:0] grant_count,
  input  logic                      stats_clr
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i]; the requester
  // holds valid/addr until then. The response is rsp_valid[i] one cycle later, with no backpressure.

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_next;
  rv32::word          w_win_addr;
  rom_arb_err_e       w_err_kind;
  logic               w_legal;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_err;
  rv32::word          r_rsp_data;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  always_comb begin
    w_win_addr = req_addr[w_idx];
    w_err_kind = rom_arb_classify(w_win_addr, ADDR_WIDTH);
    w_legal    = w_any && (w_err_kind == ROM_ARB_OK);
    w_ptr_next = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
  end

  assign req_ready = w_gnt;
  assign rom_rd_en = w_legal;
  assign rom_addr  = w_legal ? w_win_addr[ADDR_WIDTH+1:2] : '0;

  // Illegal accesses still get a response so the requester never waits forever; data is forced to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_any) begin
      r_rr_ptr    <= w_ptr_next;
      r_rsp_valid <= w_gnt;
      r_rsp_err   <= !w_legal;
      r_rsp_data  <= w_legal ? rom_rd_data : '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

`ifdef ROM_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [31:0] r_grant_cnt;

    // Clear beats a same-cycle increment; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_grant_cnt <= '0;
      end else if (stats_clr) begin
        r_grant_cnt <= '0;
      end else if (w_gnt[g] && (r_grant_cnt != 32'hFFFF_FFFF)) begin
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end
    end

    assign grant_count[g] = r_grant_cnt;
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter (NUM_REQ=3, ADDR_WIDTH=10) with a behavioural async-read ROM.
module tb_rom_arbiter;

  localparam int NR = 3;
  localparam int AW = 10;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0][31:0] req_addr;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_data;
  logic              rom_rd_en;
  logic [AW-1:0]     rom_addr;
  logic [31:0]       rom_rd_data;
`ifdef ROM_ARB_STATS_EN
  logic [NR-1:0][31:0] grant_count;
  logic              stats_clr;
`endif

  logic [31:0] rom_mem [1 << AW];
  assign rom_rd_data = rom_mem[rom_addr];

  rom_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .rom_rd_en   (rom_rd_en),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stats_clr   (stats_clr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {rsp_valid, rsp_err, rsp_data}
  logic [35:0] exp_q[$];
  logic [31:0] last_data;
  int checks;
  int failures;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input string nm);
    logic [35:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, "_rsp"}, {28'd0, rsp_valid, rsp_err, rsp_data}, {28'd0, e});
    end else begin
      chk({nm, "_rsp_idle"}, {60'd0, rsp_valid, rsp_err}, 64'd0);
    end
  endtask

  // driver: one cycle of stimulus with its combinational expectations; response expectation queued
  task automatic step(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] a2, input logic [2:0] e_rdy, input logic e_en,
                      input logic [AW-1:0] e_ra, input logic e_err, input string nm);
    logic [31:0] d;
    @(negedge clk);
    check_rsp(nm);
    req_valid   = v;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_addr[2] = a2;
    #1;
    chk({nm, "_ready"}, {61'd0, req_ready}, {61'd0, e_rdy});
    chk({nm, "_rd_en"}, {63'd0, rom_rd_en}, {63'd0, e_en});
    chk({nm, "_rom_addr"}, {54'd0, rom_addr}, {54'd0, e_ra});
    if (e_rdy != 3'b000) begin
      d = e_err ? 32'd0 : rom_mem[e_ra];
      exp_q.push_back({e_rdy, e_err, d});
      last_data = d;
    end else begin
      exp_q.push_back({3'b000, 1'b0, last_data});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    exp_q.delete();
    last_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    v;
    logic [31:0]   a0;
    logic [31:0]   a1;
    logic [31:0]   a2;
    logic [2:0]    rdy;
    logic          en;
    logic [AW-1:0] ra;
    logic          err;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [2:0] rdy, input logic en,
                              input logic [AW-1:0] ra, input logic err);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.rdy = rdy; t.en = en; t.ra = ra; t.err = err;
    return t;
  endfunction

  initial begin
    logic [2:0] rr_exp [6];
    checks    = 0;
    failures  = 0;
    last_data = '0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
`ifdef ROM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'hC0DE_0000 | 32'(i * 13 + 1);
    rom_mem[5] = 32'hDEAD_BEEF;

    // pointer walk from reset: 0 ->2 ->0 ->1 ->2 ->2 ->0 ->1 ->2 ->1 ->0 ->2 ->2 ->0 ->1
    tbl[0]  = mk(3'b010, 32'h0,         32'h14,        32'h0,  3'b010, 1'b1, 10'd5,    1'b0);
    tbl[1]  = mk(3'b111, 32'h0,         32'h4,         32'h8,  3'b100, 1'b1, 10'd2,    1'b0);
    tbl[2]  = mk(3'b111, 32'h0,         32'h4,         32'h8,  3'b001, 1'b1, 10'd0,    1'b0);
    tbl[3]  = mk(3'b111, 32'h0,         32'h4,         32'h8,  3'b010, 1'b1, 10'd1,    1'b0);
    tbl[4]  = mk(3'b000, 32'h0,         32'h0,         32'h0,  3'b000, 1'b0, 10'd0,    1'b0);
    tbl[5]  = mk(3'b100, 32'h0,         32'h0,         32'h16, 3'b100, 1'b0, 10'd0,    1'b1);
    tbl[6]  = mk(3'b001, 32'h0000_1000, 32'h0,         32'h0,  3'b001, 1'b0, 10'd0,    1'b1);
    tbl[7]  = mk(3'b011, 32'h10,        32'hFFC,       32'h0,  3'b010, 1'b1, 10'd1023, 1'b0);
    tbl[8]  = mk(3'b011, 32'h10,        32'hFFC,       32'h0,  3'b001, 1'b1, 10'd4,    1'b0);
    tbl[9]  = mk(3'b101, 32'h10,        32'h0,         32'h20, 3'b100, 1'b1, 10'd8,    1'b0);
    tbl[10] = mk(3'b110, 32'h0,         32'h8000_0000, 32'h20, 3'b010, 1'b0, 10'd0,    1'b1);
    tbl[11] = mk(3'b000, 32'h0,         32'h0,         32'h0,  3'b000, 1'b0, 10'd0,    1'b0);
    tbl[12] = mk(3'b101, 32'h3,         32'h0,         32'h24, 3'b100, 1'b1, 10'd9,    1'b0);
    tbl[13] = mk(3'b001, 32'h3,         32'h0,         32'h0,  3'b001, 1'b0, 10'd0,    1'b1);
    tbl[14] = mk(3'b000, 32'h0,         32'h0,         32'h0,  3'b000, 1'b0, 10'd0,    1'b0);

    // reset state
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", {61'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_err",   {63'd0, rsp_err},   64'd0);
    chk("reset_rsp_data",  {32'd0, rsp_data},  64'd0);
    chk("reset_ready",     {61'd0, req_ready}, 64'd0);
    chk("reset_rd_en",     {63'd0, rom_rd_en}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].rdy, tbl[i].en, tbl[i].ra,
           tbl[i].err, $sformatf("vec%0d", i));
    end

    // round-robin from reset with all requesters contending
    do_reset();
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 32'h0, 32'h4, 32'h8, rr_exp[i], 1'b1, AW'(i % 3), 1'b0, $sformatf("rr%0d", i));
    end

    // reset between grant and response: response dropped, pointer back to 0
    step(3'b001, 32'h10, 32'h14, 32'h8, 3'b001, 1'b1, 10'd4, 1'b0, "mid_pre");
    step(3'b010, 32'h10, 32'h14, 32'h8, 3'b010, 1'b1, 10'd5, 1'b0, "mid_grant");
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_rst_rsp_valid", {61'd0, rsp_valid}, 64'd0);
    chk("mid_rst_rsp_data",  {32'd0, rsp_data},  64'd0);
    #2 rst_n = 1'b1;
    exp_q.delete();
    last_data = '0;
    step(3'b111, 32'h0, 32'h4, 32'h8, 3'b001, 1'b1, 10'd0, 1'b0, "mid_after");
    step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 10'd0, 1'b0, "mid_flush");

`ifdef ROM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(3'b010, 32'h0, 32'h14, 32'h0, 3'b010, 1'b1, 10'd5, 1'b0, $sformatf("st%0d", i));
    end
    step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 10'd0, 1'b0, "st_idle");
    chk("stats_cnt1", {32'd0, grant_count[1]}, 64'd10);
    chk("stats_cnt0", {32'd0, grant_count[0]}, 64'd0);
    stats_clr = 1'b1;
    step(3'b010, 32'h0, 32'h14, 32'h0, 3'b010, 1'b1, 10'd5, 1'b0, "st_clr");
    @(posedge clk);
    #1 stats_clr = 1'b0;
    step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 10'd0, 1'b0, "st_after");
    chk("stats_cleared", {32'd0, grant_count[1]}, 64'd0);
`endif

    @(negedge clk);
    check_rsp("final");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
